// File: rtl/joint_move_sequencer.sv
// joint_move_sequencer: accepts a two-joint move, derives per-joint step scales
// with a serial restoring divider so both joints finish together, launches both
// steppers on the same cycle and waits until both report finished.
module joint_move_sequencer #(
  parameter int unsigned STEP_W  = 8,
  parameter int unsigned FRAC_W  = 8,
  parameter int unsigned SCALE_W = 16,
  parameter int unsigned SETTLE  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               move_valid,
  output logic               move_ready,
  input  logic [STEP_W-1:0]  steps1_in,
  input  logic [STEP_W-1:0]  steps2_in,
  input  logic               dir1_in,
  input  logic               dir2_in,
  input  logic               finished1,
  input  logic               finished2,
  output logic               new_out,
  output logic [STEP_W-1:0]  num_steps1,
  output logic [STEP_W-1:0]  num_steps2,
  output logic               dir1,
  output logic               dir2,
  output logic [SCALE_W-1:0] step_scale1,
  output logic [SCALE_W-1:0] step_scale2,
  output logic               busy
);

  localparam int unsigned CNT_W = (SCALE_W > 1) ? $clog2(SCALE_W) : 1;
  localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SCALE_W-1:0] SCALE_ONE = SCALE_W'(1) << FRAC_W;
  localparam logic [CNT_W-1:0]   DIV_LAST  = CNT_W'(SCALE_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIVIDE,
    S_ISSUE,
    S_SETTLE_WAIT,
    S_WAIT_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               move_ready_q, move_ready_d;
  logic               new_out_q, new_out_d;
  logic               busy_q, busy_d;
  logic [STEP_W-1:0]  num1_q, num1_d, num2_q, num2_d;
  logic               dir1_q, dir1_d, dir2_q, dir2_d;
  logic [SCALE_W-1:0] scale1_q, scale1_d, scale2_q, scale2_d;
  logic [SCALE_W-1:0] quo_q, quo_d;
  logic [STEP_W-1:0]  rem_q, rem_d;
  logic [STEP_W-1:0]  divisor_q, divisor_d;
  logic               sel2_q, sel2_d;
  logic [CNT_W-1:0]   div_cnt_q, div_cnt_d;
  logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;

  logic               sel2_c;
  logic [STEP_W-1:0]  max_c, min_c;
  logic [STEP_W:0]    trial_c, diff_c;
  logic               ge_c;
  logic [STEP_W-1:0]  rem_next_c;
  logic [SCALE_W-1:0] quo_next_c;

  // Larger/smaller step count of the offered move; joint 2 wins ties
  assign sel2_c = (steps2_in >= steps1_in);
  assign max_c  = sel2_c ? steps2_in : steps1_in;
  assign min_c  = sel2_c ? steps1_in : steps2_in;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits
  assign trial_c    = {rem_q, quo_q[SCALE_W-1]};
  assign ge_c       = (trial_c >= {1'b0, divisor_q});
  assign diff_c     = trial_c - {1'b0, divisor_q};
  assign rem_next_c = STEP_W'(ge_c ? diff_c : trial_c);
  assign quo_next_c = {quo_q[SCALE_W-2:0], ge_c};

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    move_ready_d = move_ready_q;
    new_out_d    = 1'b0;
    busy_d       = busy_q;
    num1_d       = num1_q;
    num2_d       = num2_q;
    dir1_d       = dir1_q;
    dir2_d       = dir2_q;
    scale1_d     = scale1_q;
    scale2_d     = scale2_q;
    quo_d        = quo_q;
    rem_d        = rem_q;
    divisor_d    = divisor_q;
    sel2_d       = sel2_q;
    div_cnt_d    = div_cnt_q;
    settle_cnt_d = settle_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        move_ready_d = 1'b1;
        busy_d       = 1'b0;
        if (move_valid && move_ready_q) begin
          move_ready_d = 1'b0;
          busy_d       = 1'b1;
          num1_d       = steps1_in;
          num2_d       = steps2_in;
          dir1_d       = dir1_in;
          dir2_d       = dir2_in;
          if ((steps1_in == '0) || (steps2_in == '0)) begin
            scale1_d = SCALE_ONE;
            scale2_d = SCALE_ONE;
            state_d  = S_ISSUE;
          end else begin
            sel2_d    = sel2_c;
            quo_d     = SCALE_W'({max_c, {FRAC_W{1'b0}}});
            rem_d     = '0;
            divisor_d = min_c;
            div_cnt_d = '0;
            state_d   = S_DIVIDE;
          end
        end
      end

      S_DIVIDE: begin
        quo_d     = quo_next_c;
        rem_d     = rem_next_c;
        div_cnt_d = div_cnt_q + CNT_W'(1);
        if (div_cnt_q == DIV_LAST) begin
          scale1_d = sel2_q ? SCALE_ONE : quo_next_c;
          scale2_d = sel2_q ? quo_next_c : SCALE_ONE;
          state_d  = S_ISSUE;
        end
      end

      S_ISSUE: begin
        new_out_d    = 1'b1;
        settle_cnt_d = '0;
        state_d      = S_SETTLE_WAIT;
      end

      S_SETTLE_WAIT: begin
        if (32'(settle_cnt_q) + 32'd1 >= SETTLE) begin
          state_d = S_WAIT_DONE;
        end else begin
          settle_cnt_d = settle_cnt_q + SET_W'(1);
        end
      end

      S_WAIT_DONE: begin
        if (finished1 && finished2) begin
          move_ready_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      move_ready_q <= 1'b0;
      new_out_q    <= 1'b0;
      busy_q       <= 1'b0;
      num1_q       <= '0;
      num2_q       <= '0;
      dir1_q       <= 1'b0;
      dir2_q       <= 1'b0;
      scale1_q     <= SCALE_ONE;
      scale2_q     <= SCALE_ONE;
      quo_q        <= '0;
      rem_q        <= '0;
      divisor_q    <= '0;
      sel2_q       <= 1'b0;
      div_cnt_q    <= '0;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      move_ready_q <= move_ready_d;
      new_out_q    <= new_out_d;
      busy_q       <= busy_d;
      num1_q       <= num1_d;
      num2_q       <= num2_d;
      dir1_q       <= dir1_d;
      dir2_q       <= dir2_d;
      scale1_q     <= scale1_d;
      scale2_q     <= scale2_d;
      quo_q        <= quo_d;
      rem_q        <= rem_d;
      divisor_q    <= divisor_d;
      sel2_q       <= sel2_d;
      div_cnt_q    <= div_cnt_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  assign move_ready  = move_ready_q;
  assign new_out     = new_out_q;
  assign busy        = busy_q;
  assign num_steps1  = num1_q;
  assign num_steps2  = num2_q;
  assign dir1        = dir1_q;
  assign dir2        = dir2_q;
  assign step_scale1 = scale1_q;
  assign step_scale2 = scale2_q;

endmodule

// File: tb/tb_joint_move_sequencer.sv
// Scoreboard bench for joint_move_sequencer: the driver pushes the expected
// launch for each accepted move; a monitor pops and compares on every new_out.
module tb_joint_move_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        move_valid;
  logic        move_ready;
  logic [7:0]  steps1_in, steps2_in;
  logic        dir1_in, dir2_in;
  logic        finished1, finished2;
  logic        new_out;
  logic [7:0]  num_steps1, num_steps2;
  logic        dir1, dir2;
  logic [15:0] step_scale1, step_scale2;
  logic        busy;

  typedef struct {
    logic [15:0] s1;
    logic [15:0] s2;
    logic [7:0]  n1;
    logic [7:0]  n2;
    logic        d1;
    logic        d2;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  joint_move_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .move_valid  (move_valid),
    .move_ready  (move_ready),
    .steps1_in   (steps1_in),
    .steps2_in   (steps2_in),
    .dir1_in     (dir1_in),
    .dir2_in     (dir2_in),
    .finished1   (finished1),
    .finished2   (finished2),
    .new_out     (new_out),
    .num_steps1  (num_steps1),
    .num_steps2  (num_steps2),
    .dir1        (dir1),
    .dir2        (dir2),
    .step_scale1 (step_scale1),
    .step_scale2 (step_scale2),
    .busy        (busy)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every launch pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && new_out) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_launch: new_out with empty scoreboard (cycle %0d)", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("launch_latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
        check("step_scale1", 32'(step_scale1), 32'(mon_e.s1));
        check("step_scale2", 32'(step_scale2), 32'(mon_e.s2));
        check("num_steps1", 32'(num_steps1), 32'(mon_e.n1));
        check("num_steps2", 32'(num_steps2), 32'(mon_e.n2));
        check("dir1", 32'(dir1), 32'(mon_e.d1));
        check("dir2", 32'(dir2), 32'(mon_e.d2));
      end
    end
  end

  task automatic wait_ready();
    for (int k = 0; k < 60 && !move_ready; k++) @(negedge clk);
    check("ready_before_move", 32'(move_ready), 32'd1);
  endtask

  // Issue one move, then drive finished flags at launch+f1 / launch+f2 (held)
  task automatic run_move(input logic [7:0] s1, input logic [7:0] s2,
                          input logic d1, input logic d2,
                          input logic [15:0] e1, input logic [15:0] e2,
                          input int lat, input int f1, input int f2, input bit poke);
    exp_t e;
    int   exp_k;
    int   kr;
    int   bad;
    wait_ready();
    steps1_in  = s1;
    steps2_in  = s2;
    dir1_in    = d1;
    dir2_in    = d2;
    move_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    move_valid = 1'b0;
    e.s1 = e1; e.s2 = e2; e.n1 = s1; e.n2 = s2; e.d1 = d1; e.d2 = d2;
    e.lat = lat; e.acc = cyc;
    sb_q.push_back(e);
    check("busy_after_accept", 32'(busy), 32'd1);
    check("ready_low_after_accept", 32'(move_ready), 32'd0);
    for (int k = 0; k < 40 && !new_out; k++) @(negedge clk);
    check("launch_seen", 32'(new_out), 32'd1);
    if (new_out !== 1'b1) return;
    check("busy_at_launch", 32'(busy), 32'd1);
    exp_k = (f1 > f2) ? f1 : f2;
    if (exp_k < 2) exp_k = 2;
    exp_k = exp_k + 1;
    if (f1 == 0) finished1 = 1'b1;
    if (f2 == 0) finished2 = 1'b1;
    kr  = 0;
    bad = 0;
    for (int k = 1; k <= 60 && kr == 0; k++) begin
      @(negedge clk);
      if (k == 1) check("new_out_one_cycle", 32'(new_out), 32'd0);
      if (num_steps1 !== s1 || num_steps2 !== s2 || dir1 !== d1 || dir2 !== d2 ||
          step_scale1 !== e1 || step_scale2 !== e2) bad++;
      if (move_ready) begin
        kr = k;
      end else begin
        if (k == f1) finished1 = 1'b1;
        if (k == f2) finished2 = 1'b1;
        if (poke && k == 4) begin
          steps1_in  = 8'd7;
          steps2_in  = 8'd9;
          dir1_in    = ~d1;
          move_valid = 1'b1;
        end
        if (poke && k == 5) move_valid = 1'b0;
      end
    end
    move_valid = 1'b0;
    check("ready_return_cycle", 32'(kr), 32'(exp_k));
    check("busy_after_done", 32'(busy), 32'd0);
    check("outputs_stable", 32'(bad), 32'd0);
    finished1 = 1'b0;
    finished2 = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    move_valid = 1'b0;
    steps1_in  = '0;
    steps2_in  = '0;
    dir1_in    = 1'b0;
    dir2_in    = 1'b0;
    finished1  = 1'b0;
    finished2  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_move_ready", 32'(move_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_new_out", 32'(new_out), 32'd0);
    check("rst_scale1", 32'(step_scale1), 32'd256);
    check("rst_scale2", 32'(step_scale2), 32'd256);
    check("rst_num1", 32'(num_steps1), 32'd0);
    check("rst_num2", 32'(num_steps2), 32'd0);
    check("rst_dirs", 32'({dir1, dir2}), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_reset", 32'(move_ready), 32'd1);

    run_move(8'd100, 8'd25, 1'b1, 1'b0, 16'd1024, 16'd256, 17, 3, 3, 1'b0);
    run_move(8'd3, 8'd200, 1'b0, 1'b1, 16'd256, 16'd17066, 17, 5, 5, 1'b0);
    run_move(8'd0, 8'd50, 1'b1, 1'b1, 16'd256, 16'd256, 1, 2, 2, 1'b0);
    run_move(8'd40, 8'd40, 1'b0, 1'b0, 16'd256, 16'd256, 17, 5, 9, 1'b1);
    run_move(8'd0, 8'd0, 1'b0, 1'b1, 16'd256, 16'd256, 1, 0, 0, 1'b0);
    run_move(8'd255, 8'd1, 1'b1, 1'b0, 16'd65280, 16'd256, 17, 0, 0, 1'b0);

    // Abort a move mid-divide; it must never launch
    wait_ready();
    steps1_in  = 8'd100;
    steps2_in  = 8'd25;
    dir1_in    = 1'b1;
    dir2_in    = 1'b1;
    move_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    move_valid = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_new_out", 32'(new_out), 32'd0);
    check("midrst_scale1", 32'(step_scale1), 32'd256);
    check("midrst_scale2", 32'(step_scale2), 32'd256);
    check("midrst_num1", 32'(num_steps1), 32'd0);
    check("midrst_num2", 32'(num_steps2), 32'd0);
    check("midrst_dirs", 32'({dir1, dir2}), 32'd0);
    check("midrst_ready_low", 32'(move_ready), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_ready_after", 32'(move_ready), 32'd1);

    run_move(8'd100, 8'd25, 1'b0, 1'b1, 16'd1024, 16'd256, 17, 4, 2, 1'b0);

    repeat (30) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/joint_move_sequencer.md
# joint_move_sequencer

Sequences coordinated two-joint moves between `ScaraController` and the two `stepper_motor` instances. It accepts one move (step counts and directions for both joints) per handshake and computes per-joint `step_scale` values with a multi-cycle divider, so both joints finish together. It then launches both steppers on the same cycle and holds off the controller until both report finished. It replaces the combinational divide/scale logic currently instantiated beside the steppers.

## Interface
Parameters:
- `STEP_W`, 8, width of step counts
- `FRAC_W`, 8, fractional bits of scale (scale 1.0 = 1 << FRAC_W)
- `SCALE_W`, 16, width of step_scale outputs (= STEP_W + FRAC_W)
- `SETTLE`, 2, cycles after launch during which finished inputs are ignored

Ports:
- `clk`  in  1  system clock (50 MHz); sole clock
- `reset`  in  1  synchronous, active-high reset
- `move_valid`  in  1  controller has a move (dataReady)
- `move_ready`  out  1  sequencer can accept a move (to readyForNewData path)
- `steps1_in`, `steps2_in`  in  STEP_W  requested steps per joint
- `dir1_in`, `dir2_in`  in  1  requested direction per joint
- `finished1`, `finished2`  in  1  stepper_motor finished flags
- `new_out`  out  1  one-cycle launch pulse to both steppers' new_in
- `num_steps1`, `num_steps2`  out  STEP_W  registered step counts to steppers
- `dir1`, `dir2`  out  1  registered directions
- `step_scale1`, `step_scale2`  out  SCALE_W  registered fixed-point scales
- `busy`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, DIVIDE, ISSUE, SETTLE_WAIT, WAIT_DONE.
- IDLE: `move_ready`=1. On `move_valid`&&`move_ready`, latch steps/dirs into the output registers. Move to DIVIDE, or to ISSUE when either step count is 0.
- Zero path: if either count is 0, both scales = 1 << FRAC_W.
- DIVIDE: restoring divider computes quotient = (max << FRAC_W) / min, where max/min are the larger/smaller step counts. It produces one quotient bit per cycle, SCALE_W cycles. The quotient goes to the scale of the joint with the larger count; the other joint's scale = 1 << FRAC_W. On a tie (steps1 == steps2), joint 2 takes the quotient, which equals 1 << FRAC_W.
- Arithmetic: dividend width SCALE_W. The maximum quotient, 255·256/1 = 65280, fits, so there is no saturation. The result is truncated, not rounded.
- ISSUE: `new_out`=1 for exactly one cycle, then SETTLE_WAIT.
- SETTLE_WAIT: count SETTLE cycles while ignoring `finished*`, then WAIT_DONE.
- WAIT_DONE: when `finished1`&&`finished2` are sampled high on the same cycle, go to IDLE.
- `move_valid` outside IDLE is ignored. Inputs are not latched and there is no queue.
- Output registers (`num_steps*`, `dir*`, `step_scale*`) hold their value until the next accepted move.

## Timing
- Reset values: `move_ready`=0 while `reset`=1; state=IDLE; `new_out`=0; `busy`=0; `num_steps*`=0; `dir*`=0; `step_scale*`=1 << FRAC_W (256).
- `move_ready`=1 on the first cycle after `reset` deasserts.
- Accept at edge T:
  - divide path: `step_scale*` valid and `new_out` high in cycle T+SCALE_W+1 (T+17 default).
  - zero path: `new_out` high in cycle T+1.
- `num_steps*`, `dir*` and `step_scale*` are stable from the `new_out` cycle through WAIT_DONE exit.
- Earliest WAIT_DONE exit is the `new_out` cycle + SETTLE + 1. `move_ready` rises the cycle after both finished flags are seen. Back-to-back accept is possible on that cycle.
- Finished flags rising on different cycles: exit only once both are high simultaneously.
- Reset mid-operation (any state): next cycle is IDLE with all outputs at reset values. An in-flight `new_out` is dropped. Steppers are reset by their own reset_n.
- Both counts 0: the zero path still issues `new_out`, and steppers complete immediately.

## Test plan
- steps1=100, steps2=25, dir1=1, dir2=0 accepted at T -> `new_out` at T+17; `step_scale1`=1024, `step_scale2`=256; `num_steps1`=100, `num_steps2`=25.
- steps1=3, steps2=200 -> `step_scale2`=17066 (0x42AA), `step_scale1`=256; `move_ready` returns the cycle after both finished are high.
- steps1=0, steps2=50 -> `new_out` at T+1; both scales 256; `busy` high from T+1 until done.
- steps1=40, steps2=40 -> divide path, `new_out` at T+17, both scales 256. Pulse `move_valid` with other values during WAIT_DONE -> ignored, outputs unchanged.
- Raise `finished1` at launch+5 and `finished2` at launch+9 (held) -> IDLE entered after launch+9; finished held high during SETTLE is not treated as done.
- Assert `reset` at T+8 mid-DIVIDE -> next cycle `busy`=0, `new_out`=0, scales=256, `num_steps*`=0. `move_ready`=1 one cycle after reset drops. A fresh move then completes normally.
